// File: rtl/scm_pkg.sv
// scm_pkg: shared types and encodings for the SCM core.
//   state_e   : core sequencing states
//   instr_t   : 64-bit instruction word {op, a, b, d}
//   CLS_*     : instruction class codes (op[13:12])
//   ALU_*     : ALU function codes (op[7:0])
//   CND_*     : conditional-jump compare codes (op[7:0])
//   HALT_OP, DEST_PC, DEST_NONE : special opcode / destination encodings
package scm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  typedef struct packed {
    logic [15:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
  } instr_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_COND  = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [7:0] ALU_ADD = 8'd0;
  localparam logic [7:0] ALU_SUB = 8'd1;
  localparam logic [7:0] ALU_AND = 8'd2;
  localparam logic [7:0] ALU_OR  = 8'd3;
  localparam logic [7:0] ALU_XOR = 8'd4;
  localparam logic [7:0] ALU_NOT = 8'd5;
  localparam logic [7:0] ALU_SHL = 8'd6;
  localparam logic [7:0] ALU_SHR = 8'd7;

  localparam logic [7:0] CND_EQ     = 8'd0;
  localparam logic [7:0] CND_NE     = 8'd1;
  localparam logic [7:0] CND_LT     = 8'd2;
  localparam logic [7:0] CND_LE     = 8'd3;
  localparam logic [7:0] CND_GT     = 8'd4;
  localparam logic [7:0] CND_GE     = 8'd5;
  localparam logic [7:0] CND_ALWAYS = 8'd6;

  localparam logic [15:0] HALT_OP   = 16'hFFFF;
  localparam logic [7:0]  DEST_PC   = 8'hFE;
  localparam logic [7:0]  DEST_NONE = 8'hFF;

endpackage

// File: rtl/scm_exec_unit.sv
// scm_exec_unit: combinational ALU and unsigned comparator.
//   op_a, op_b : operands
//   func       : function code, interpreted as ALU op and as compare op
//   alu_c      : ALU result (mod 2^DATA_W)
//   cond_c     : compare outcome
module scm_exec_unit
  import scm_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [7:0]        func,
  output logic [DATA_W-1:0] alu_c,
  output logic              cond_c
);

  // ALU
  always_comb begin
    alu_c = '0;
    case (func)
      ALU_ADD: alu_c = op_a + op_b;
      ALU_SUB: alu_c = op_a - op_b;
      ALU_AND: alu_c = op_a & op_b;
      ALU_OR:  alu_c = op_a | op_b;
      ALU_XOR: alu_c = op_a ^ op_b;
      ALU_NOT: alu_c = ~op_a;
      ALU_SHL: alu_c = op_a << op_b[5:0];
      ALU_SHR: alu_c = op_a >> op_b[5:0];
      default: alu_c = '0;
    endcase
  end

  // unsigned comparator; unknown codes never take the jump
  always_comb begin
    cond_c = 1'b0;
    case (func)
      CND_EQ:     cond_c = (op_a == op_b);
      CND_NE:     cond_c = (op_a != op_b);
      CND_LT:     cond_c = (op_a <  op_b);
      CND_LE:     cond_c = (op_a <= op_b);
      CND_GT:     cond_c = (op_a >  op_b);
      CND_GE:     cond_c = (op_a >= op_b);
      CND_ALWAYS: cond_c = 1'b1;
      default:    cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/scm_core.sv
// scm_core: multi-cycle SCM core with instruction fetch and data-memory ports.
//   clk, rst          : clock, asynchronous active-high reset
//   run               : start/continue, sampled at instruction boundaries
//   if_req/if_addr    : fetch request and PC; if_ack/if_data complete it
//   mem_req/mem_we/mem_addr/mem_wdata : data access; mem_ack/mem_rdata complete it
//   halted            : sticky halt flag
//   retired           : retired instruction count (wraps)
module scm_core
  import scm_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              if_req,
  output logic [PC_W-1:0]   if_addr,
  input  logic              if_ack,
  input  logic [63:0]       if_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e              state_q, state_d;
  instr_t              ir;
  logic [DATA_W-1:0]   regs [REG_COUNT];
  logic [DATA_W-1:0]   rd_a, rd_b, op_a, op_b, alu_c, rf_wdata;
  logic                cond_c, ir_load, rf_we, retire, mem_load;
  logic [PC_W-1:0]     pc_d;
  logic [1:0]          cls;

  assign cls = ir.op[13:12];

  // register reads; indices past the file read as zero
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (ir.a[7:0] == 8'(i)) rd_a = regs[i];
      if (ir.b[7:0] == 8'(i)) rd_b = regs[i];
    end
  end

  assign op_a = ir.op[15] ? DATA_W'(ir.a) : rd_a;
  assign op_b = ir.op[14] ? DATA_W'(ir.b) : rd_b;

  scm_exec_unit #(.DATA_W(DATA_W)) u_exec (
    .op_a   (op_a),
    .op_b   (op_b),
    .func   (ir.op[7:0]),
    .alu_c  (alu_c),
    .cond_c (cond_c)
  );

  // next state and commit strobes
  always_comb begin
    state_d  = state_q;
    pc_d     = if_addr;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_c;
    retire   = 1'b0;
    mem_load = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (if_ack) begin
          ir_load = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir.op == HALT_OP) begin
          state_d = S_HALT;
        end else if (cls == CLS_ALU) begin
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
          if (ir.d[7:0] == DEST_PC) begin
            pc_d = PC_W'(alu_c);
          end else begin
            pc_d  = if_addr + PC_W'(1);
            rf_we = (ir.d[7:0] != DEST_NONE);
          end
        end else if (cls == CLS_COND) begin
          retire  = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
          pc_d    = cond_c ? PC_W'(ir.d) : if_addr + PC_W'(1);
        end else begin
          mem_load = 1'b1;
          state_d  = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          retire   = 1'b1;
          pc_d     = if_addr + PC_W'(1);
          state_d  = run ? S_FETCH : S_IDLE;
          rf_we    = (cls == CLS_LOAD);
          rf_wdata = mem_rdata;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // state, PC, register file and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir        <= '0;
      if_req    <= 1'b0;
      if_addr   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retired   <= '0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      if_addr <= pc_d;
      if_req  <= (state_d == S_FETCH);
      mem_req <= (state_d == S_MEM);
      halted  <= (state_d == S_HALT);
      if (ir_load) ir <= instr_t'(if_data);
      if (retire) retired <= retired + CNT_W'(1);
      if (mem_load) begin
        mem_we    <= (cls == CLS_STORE);
        mem_addr  <= (cls == CLS_LOAD) ? op_a + op_b : op_a;
        mem_wdata <= op_b;
      end
      for (int i = 0; i < REG_COUNT; i++) begin
        if (rf_we && ir.d[7:0] == 8'(i)) regs[i] <= rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_scm_core.sv
// tb_scm_core: directed bench for scm_core, default build plus an 8-bit/4-register build.
module tb_scm_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [63:0] if_data = '0;
  logic [15:0] mem_rdata = '0;
  logic        if_ack1 = 1'b0, if_ack2 = 1'b0, mem_ack1 = 1'b0, mem_ack2 = 1'b0;
  logic        if_req1, if_req2, mem_req1, mem_req2, mem_we1, mem_we2, halted1, halted2;
  logic [15:0] if_addr1, if_addr2, mem_addr1, mem_wdata1;
  logic [7:0]  mem_addr2, mem_wdata2;
  logic [31:0] retired1, retired2;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  scm_core dut (
    .clk(clk), .rst(rst), .run(run),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_data(if_data),
    .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_ack(mem_ack1), .mem_rdata(mem_rdata),
    .halted(halted1), .retired(retired1)
  );

  scm_core #(.DATA_W(8), .REG_COUNT(4)) dut8 (
    .clk(clk), .rst(rst), .run(run),
    .if_req(if_req2), .if_addr(if_addr2), .if_ack(if_ack2), .if_data(if_data),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata[7:0]),
    .halted(halted2), .retired(retired2)
  );

  function automatic logic [63:0] ins(input logic [15:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] d);
    return {op, a, b, d};
  endfunction

  function automatic logic ireq(input int sel);
    return (sel == 0) ? if_req1 : if_req2;
  endfunction

  function automatic logic [15:0] iaddr(input int sel);
    return (sel == 0) ? if_addr1 : if_addr2;
  endfunction

  function automatic logic mreq(input int sel);
    return (sel == 0) ? mem_req1 : mem_req2;
  endfunction

  // {we, addr, wdata}, narrow build zero-extended
  function automatic logic [32:0] mfields(input int sel);
    return (sel == 0) ? {mem_we1, mem_addr1, mem_wdata1}
                      : {mem_we2, 8'h00, mem_addr2, 8'h00, mem_wdata2};
  endfunction

  // serve one fetch: request held 'hold' cycles (1 = zero-wait) then acked
  task automatic do_fetch(input int sel, input logic [63:0] instr, input int hold,
                          output logic [15:0] addr, output bit ok);
    int n;
    ok = 1'b0; addr = '0; n = 0;
    while (!ireq(sel) && n < 40) begin @(negedge clk); n++; end
    if (!ireq(sel)) return;
    ok = 1'b1; addr = iaddr(sel);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (!ireq(sel) || iaddr(sel) !== addr) ok = 1'b0;
    end
    if_data = instr;
    if (sel == 0) if_ack1 = 1'b1; else if_ack2 = 1'b1;
    @(negedge clk);
    if_ack1 = 1'b0; if_ack2 = 1'b0; if_data = '0;
    if (ireq(sel)) ok = 1'b0;
  endtask

  // serve one data access the same way, capturing its fields
  task automatic do_mem(input int sel, input int hold, input logic [15:0] rdata,
                        output logic [32:0] f, output bit ok);
    int n;
    ok = 1'b0; f = '0; n = 0;
    while (!mreq(sel) && n < 40) begin @(negedge clk); n++; end
    if (!mreq(sel)) return;
    ok = 1'b1; f = mfields(sel);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (!mreq(sel) || mfields(sel) !== f) ok = 1'b0;
    end
    mem_rdata = rdata;
    if (sel == 0) mem_ack1 = 1'b1; else mem_ack2 = 1'b1;
    @(negedge clk);
    mem_ack1 = 1'b0; mem_ack2 = 1'b0; mem_rdata = '0;
    if (mreq(sel)) ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({if_req1, mem_req1, mem_we1, halted1} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl got %b want 0000", {if_req1, mem_req1, mem_we1, halted1});
    end
    tests++;
    if ({if_addr1, mem_addr1, mem_wdata1} !== 48'h0) begin
      fails++; $display("FAIL reset_addr got %h want 0", {if_addr1, mem_addr1, mem_wdata1});
    end
    tests++;
    if (retired1 !== 32'd0) begin
      fails++; $display("FAIL reset_retired got %0d want 0", retired1);
    end
  endtask

  task automatic test_alu;
    logic [15:0] a;
    bit ok;
    rst = 1'b0; run = 1'b1;
    do_fetch(0, ins(16'hC000, 16'd3, 16'd4, 16'd0), 1, a, ok);
    tests++;
    if (!ok || a !== 16'h0000) begin
      fails++; $display("FAIL alu_fetch ok=%0d addr=%h want ok=1 addr=0000", ok, a);
    end
    @(negedge clk);
    tests++;
    if ({if_req1, if_addr1} !== {1'b1, 16'h0001}) begin
      fails++; $display("FAIL alu_next_fetch req=%b addr=%h want 1 0001", if_req1, if_addr1);
    end
    tests++;
    if (retired1 !== 32'd1) begin
      fails++; $display("FAIL alu_retired got %0d want 1", retired1);
    end
  endtask

  task automatic test_cond;
    logic [63:0] prog [3];
    logic [15:0] exp_pc [3];
    logic [15:0] a;
    bit ok;
    prog[0] = ins(16'h5002, 16'h0000, 16'd9, 16'h0020); exp_pc[0] = 16'h0020; // 7 < 9 taken
    prog[1] = ins(16'h5002, 16'h0000, 16'd5, 16'h0040); exp_pc[1] = 16'h0021; // 7 < 5 not taken
    prog[2] = ins(16'hC000, 16'h0010, 16'h0005, 16'h00FE); exp_pc[2] = 16'h0015; // ALU to PC
    for (int i = 0; i < 3; i++) begin
      do_fetch(0, prog[i], 1, a, ok);
      @(negedge clk);
      tests++;
      if (!ok || {if_req1, if_addr1} !== {1'b1, exp_pc[i]} || retired1 !== 32'(i + 2)) begin
        fails++;
        $display("FAIL cond_%0d ok=%0d pc=%h retired=%0d want pc=%h retired=%0d",
                 i, ok, if_addr1, retired1, exp_pc[i], i + 2);
      end
    end
  endtask

  task automatic test_mem;
    logic [15:0] a;
    logic [32:0] f;
    bit ok, ok2;
    do_fetch(0, ins(16'hF000, 16'h0100, 16'hBEEF, 16'h0000), 1, a, ok);
    do_mem(0, 3, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || f !== {1'b1, 16'h0100, 16'hBEEF}) begin
      fails++; $display("FAIL store ok=%0d/%0d fields=%h want 1_0100_beef", ok, ok2, f);
    end
    do_fetch(0, ins(16'hE000, 16'h0080, 16'h0080, 16'h0002), 1, a, ok);
    do_mem(0, 3, 16'hBEEF, f, ok2);
    tests++;
    if (!ok || !ok2 || f[32:16] !== {1'b0, 16'h0100}) begin
      fails++; $display("FAIL load ok=%0d/%0d we_addr=%h want 0_0100", ok, ok2, f[32:16]);
    end
    do_fetch(0, ins(16'hB000, 16'h0010, 16'h0002, 16'h0000), 1, a, ok);
    do_mem(0, 1, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || f !== {1'b1, 16'h0010, 16'hBEEF}) begin
      fails++; $display("FAIL load_r2 ok=%0d/%0d fields=%h want 1_0010_beef", ok, ok2, f);
    end
    tests++;
    if (retired1 !== 32'd7 || a !== 16'h0017) begin
      fails++; $display("FAIL mem_retired got %0d pc=%h want 7 pc=0017", retired1, a);
    end
  endtask

  task automatic test_run_stop;
    logic [15:0] a;
    bit ok, hi;
    run = 1'b0;
    do_fetch(0, ins(16'hC000, 16'd1, 16'd1, 16'd3), 1, a, ok);
    tests++;
    if (!ok || a !== 16'h0018) begin
      fails++; $display("FAIL stop_fetch ok=%0d addr=%h want 1 0018", ok, a);
    end
    hi = 1'b0;
    repeat (5) begin @(negedge clk); if (if_req1) hi = 1'b1; end
    tests++;
    if (hi || retired1 !== 32'd8) begin
      fails++; $display("FAIL stop_idle req_seen=%0d retired=%0d want 0 8", hi, retired1);
    end
    run = 1'b1;
    @(negedge clk);
    tests++;
    if ({if_req1, if_addr1} !== {1'b1, 16'h0019}) begin
      fails++; $display("FAIL restart req=%b addr=%h want 1 0019", if_req1, if_addr1);
    end
  endtask

  task automatic test_halt;
    logic [15:0] a;
    bit ok, hi;
    do_fetch(0, ins(16'hFFFF, 16'h0, 16'h0, 16'h0), 1, a, ok);
    @(negedge clk);
    tests++;
    if (!ok || halted1 !== 1'b1 || if_req1 !== 1'b0 || retired1 !== 32'd8) begin
      fails++; $display("FAIL halt ok=%0d halted=%b req=%b retired=%0d want 1 1 0 8",
                        ok, halted1, if_req1, retired1);
    end
    hi = 1'b0;
    if_ack1 = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (if_req1 || mem_req1 || !halted1) hi = 1'b1;
    end
    if_ack1 = 1'b0;
    tests++;
    if (hi || retired1 !== 32'd8) begin
      fails++; $display("FAIL halt_hold activity=%0d retired=%0d want 0 8", hi, retired1);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] a;
    logic [32:0] f;
    bit ok, ok2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_fetch(0, ins(16'hC000, 16'd1, 16'd1, 16'd0), 1, a, ok);
    @(negedge clk);
    tests++;
    if (!ok || {if_req1, if_addr1} !== {1'b1, 16'h0001}) begin
      fails++; $display("FAIL pre_rst ok=%0d req=%b addr=%h want 1 1 0001", ok, if_req1, if_addr1);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({if_req1, mem_req1, if_addr1, retired1} !== 50'h0) begin
      fails++; $display("FAIL async_rst req=%b mreq=%b addr=%h retired=%0d want all 0",
                        if_req1, mem_req1, if_addr1, retired1);
    end
    @(negedge clk);
    rst = 1'b0;
    do_fetch(0, ins(16'hB000, 16'h0000, 16'h0000, 16'h0000), 1, a, ok);
    do_mem(0, 1, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || a !== 16'h0000 || f !== 33'h1_0000_0000) begin
      fails++; $display("FAIL rst_regs ok=%0d/%0d pc=%h fields=%h want pc=0000 fields=1_0000_0000",
                        ok, ok2, a, f);
    end
  endtask

  task automatic test_narrow;
    logic [15:0] a;
    logic [32:0] f;
    bit ok, ok2;
    do_fetch(1, ins(16'hC000, 16'h12FF, 16'h0002, 16'h0001), 1, a, ok);
    do_fetch(1, ins(16'hB000, 16'h0000, 16'h0001, 16'h0000), 1, a, ok2);
    do_mem(1, 1, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || f !== 33'h1_0000_0001) begin
      fails++; $display("FAIL n8_add_wrap ok=%0d/%0d fields=%h want 1_0000_0001", ok, ok2, f);
    end
    do_fetch(1, ins(16'hC000, 16'h0033, 16'h0000, 16'h0005), 1, a, ok);
    do_fetch(1, ins(16'hB000, 16'h0000, 16'h0005, 16'h0000), 1, a, ok2);
    do_mem(1, 1, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || f !== 33'h1_0000_0000) begin
      fails++; $display("FAIL n8_oob_read ok=%0d/%0d fields=%h want 1_0000_0000", ok, ok2, f);
    end
    do_fetch(1, ins(16'hB000, 16'h0000, 16'h0001, 16'h0000), 1, a, ok);
    do_mem(1, 1, 16'h0000, f, ok2);
    tests++;
    if (!ok || !ok2 || f !== 33'h1_0000_0001) begin
      fails++; $display("FAIL n8_oob_write ok=%0d/%0d fields=%h want 1_0000_0001", ok, ok2, f);
    end
    tests++;
    if (a !== 16'h0004 || retired2 !== 32'd5) begin
      fails++; $display("FAIL n8_count pc=%h retired=%0d want 0004 5", a, retired2);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_cond();
    test_mem();
    test_run_stop();
    test_halt();
    test_reset_mid();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/scm_core.md
# scm_core

Parametrised successor to the SCM16 datapath. A multi-cycle core that fetches 64-bit instructions over a request/acknowledge port, executes ALU and conditional-jump operations, and adds load/store over a second handshaked data-memory port. Data width, register count and PC width are generic. Sits between the program store and the shared RAM at the top of the SCM system.

## Interface
- DATA_W, 16, datapath/register width (8..64); immediates zero-extended or truncated to DATA_W
- REG_COUNT, 8, general registers (1..254); operand index >= REG_COUNT reads 0, write is discarded
- PC_W, 16, instruction-address width
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start/continue; sampled at instruction boundaries only
- if_req  out  1  fetch request
- if_addr  out  PC_W  instruction index (PC)
- if_ack  in  1  fetch complete; if_data valid this cycle
- if_data  in  64  {op[63:48], a[47:32], b[31:16], d[15:0]}
- mem_req  out  1  data-memory request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  DATA_W  data address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  access complete; mem_rdata valid this cycle on loads
- mem_rdata  in  DATA_W  load data
- halted  out  1  sticky halt flag
- retired  out  CNT_W  instructions retired since reset, wraps

## Operation
- op == 16'hFFFF: halt. Otherwise op[15]=IMM_A, op[14]=IMM_B, op[13:12]=class (00 ALU, 01 COND, 10 LOAD, 11 STORE), op[7:0]=func.
- Operand A = IMM_A ? a : R[a[7:0]]; B likewise from b.
- ALU func: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[5:0], 7 SHR (logical); other func yields 0. Result mod 2^DATA_W, no flags.
- ALU dest d[7:0]: register index; 8'hFE = PC (jump to result[PC_W-1:0]); 8'hFF = discard.
- COND func (unsigned): 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 ALWAYS, other NEVER. True: PC <= d[PC_W-1:0]; false: PC+1.
- LOAD: mem_addr = A+B, R[d] <= mem_rdata. STORE: mem_addr = A, mem_wdata = B.
- States: IDLE -> FETCH when run=1. FETCH -> EXEC on if_ack (instruction latched). EXEC: halt op -> HALT; ALU/COND commit -> FETCH if run else IDLE; LOAD/STORE -> MEM. MEM -> FETCH/IDLE on mem_ack, load data committed. HALT absorbing until reset.
- retired increments on ALU/COND commit and MEM ack; halt op not counted.
- PC increments mod 2^PC_W; no jump unless COND true or ALU dest 8'hFE.

## Timing
- Reset: state IDLE, PC 0, all registers 0, retired 0, halted 0, if_req/mem_req/mem_we 0, if_addr/mem_addr/mem_wdata 0.
- All outputs registered. if_req rises on the edge entering FETCH and holds, if_addr stable, until the cycle if_ack=1. Same rule for mem_req with mem_addr/mem_we/mem_wdata stable.
- if_ack outside FETCH and mem_ack outside MEM ignored.
- Minimum throughput with zero-wait ack: ALU/COND 2 cycles, LOAD/STORE 3 cycles.
- run=0 mid-instruction: instruction completes, then IDLE; no request dropped.
- rst mid-handshake: requests deassert immediately (asynchronous), no commit.
- halted rises on the edge leaving EXEC with the halt op; no further requests.

## Structure
- Package scm_pkg: state enum, class codes, ALU/COND func codes, HALT_OP, DEST_PC, DEST_NONE.
- Sub-module scm_exec_unit: combinational ALU + comparator, parametrised by DATA_W; core holds FSM, PC, register file, counters.

## Test plan
- Reset then run=1, ADD imm 3 + imm 4 -> R0, zero-wait fetch -> R0=7, retired=1, next if_addr=1 two cycles after first if_req.
- COND LT R0(7) < imm 9, d=0x20 -> if_addr=0x20; repeat with imm 5 -> if_addr=PC+1.
- STORE A=0x100, B=0xBEEF, then LOAD A=0x80,B=0x80 -> R2 with 3-cycle mem_ack delay -> mem_req held 3 cycles, R2=0xBEEF, fields stable throughout.
- op=0xFFFF -> halted=1, if_req stays 0 for 20 cycles, retired unchanged.
- rst asserted while if_req=1 with ack pending -> if_req=0 same cycle, PC=0, registers 0.
- DATA_W=8, REG_COUNT=4: ADD 0xFF+0x02 -> 0x01; write to d=5 discarded, read index 5 yields 0.
